// File: rtl/pc_seq.sv
// Program-counter sequencer: sequential advance, absolute/relative redirects,
// trap vectoring and a circular return-address stack with overflow/underflow pulses.
module pc_seq #(
  parameter int                 PC_W      = 32,
  parameter int                 OFF_W     = 16,
  parameter int                 STEP      = 4,
  parameter int                 RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]    RESET_VEC = '0,
  parameter logic [PC_W-1:0]    TRAP_VEC  = PC_W'('h100),
  localparam int                LVL_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en_cnt,
  input  logic               en_offset,
  input  logic [OFF_W-1:0]   pc_offset,
  input  logic               en_jump,
  input  logic [PC_W-1:0]    jump_addr,
  input  logic               en_call,
  input  logic               en_ret,
  input  logic               en_trap,
  input  logic               fetch_ready,
  output logic [PC_W-1:0]    pc_cnt,
  output logic               fetch_valid,
  output logic [LVL_W-1:0]   ras_level,
  output logic               ras_overflow,
  output logic               ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int SHIFT = $clog2(STEP);

  // Handshake: pc_cnt is offered while fetch_valid=1; a sequential advance
  // happens only when en_cnt && fetch_ready. Redirects ignore fetch_ready
  // and force fetch_valid low for exactly one cycle (bubble).

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             fv_q, fv_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  logic [PC_W-1:0]  pc_seq_w;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  rel_tgt;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] top_idx;
  logic             stack_full;
  logic             stack_empty;
  logic             push;

  assign pc_seq_w    = pc_q + PC_W'(STEP);
  assign off_ext     = PC_W'($signed(pc_offset));
  assign rel_tgt     = pc_q + (off_ext << SHIFT);
  assign ptr_inc     = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign top_idx     = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - 1'b1;
  assign stack_full  = (lvl_q == LVL_W'(RAS_DEPTH));
  assign stack_empty = (lvl_q == '0);

  always_comb begin
    pc_d  = pc_q;
    fv_d  = 1'b1;
    lvl_d = lvl_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    ptr_d = ptr_q;
    push  = 1'b0;
    if (en_trap) begin
      pc_d = TRAP_VEC;
      fv_d = 1'b0;
    end else if (en_jump) begin
      pc_d = jump_addr;
      fv_d = 1'b0;
    end else if (en_offset) begin
      pc_d = rel_tgt;
      fv_d = 1'b0;
    end else if (en_call) begin
      pc_d  = rel_tgt;
      fv_d  = 1'b0;
      push  = 1'b1;
      ptr_d = ptr_inc;
      // A full stack overwrites its oldest slot, which is the one ptr_q points at.
      if (stack_full) ovf_d = 1'b1;
      else            lvl_d = lvl_q + 1'b1;
    end else if (en_ret) begin
      fv_d = 1'b0;
      if (stack_empty) begin
        pc_d  = pc_seq_w;
        unf_d = 1'b1;
      end else begin
        pc_d  = ras_q[top_idx];
        ptr_d = top_idx;
        lvl_d = lvl_q - 1'b1;
      end
    end else if (en_cnt && fetch_ready) begin
      pc_d = pc_seq_w;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      fv_q  <= 1'b0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ptr_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      fv_q  <= fv_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ptr_q <= ptr_d;
      if (push) ras_q[ptr_q] <= pc_seq_w;
    end
  end

  assign pc_cnt        = pc_q;
  assign fetch_valid   = fv_q;
  assign ras_level     = lvl_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
